// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: IF byte fetches pass straight through; MEM loads/stores of 1/2/4 bytes take priority.
// Optional `MEM_CTRL_IO_WAIT_EN inserts one idle cycle after each MEM byte that targets IO space (addr[17:16] == 2'b11).
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_request_i,
    input  logic [31:0] if_addr_i,
    output logic [7:0]  mem_ctrl_data_o,
    output logic [1:0]  if_or_mem_o,
    input  logic [1:0]  mem_request_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        stall_req_o,
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

`ifdef MEM_CTRL_IO_WAIT_EN
    function automatic logic is_io(input logic [31:0] a);
        return (a[17:16] == 2'b11);
    endfunction
`endif

    state_t      state_r, state_s;
    logic [31:0] addr_r;
    logic [2:0]  len_r, len_s;
    logic [31:0] wdata_r;
    logic [2:0]  k_r, k_s;
    logic [31:0] rdata_r, rdata_s;
    logic        cap_pend_r, cap_pend_s;
    logic        gap_r, gap_s;
    logic [31:0] mem_rdata_r, rdata_out_s;
    logic        mem_done_r, done_s;
    logic [1:0]  owner_r, owner_s;
    logic        lat_s;
    logic [31:0] cur_addr_s;
    logic [7:0]  wr_byte_s;
    logic [1:0]  cap_idx_s;
    logic [31:0] rdata_cap_s;
    logic [31:0] ram_addr_s;
    logic [7:0]  ram_dout_s;
    logic        ram_wr_s;
    logic        stall_s;
    logic        mem_req_valid_s;

    assign mem_ctrl_data_o = ram_din_i;
    assign mem_rdata_o     = mem_rdata_r;
    assign mem_done_o      = mem_done_r;
    assign if_or_mem_o     = owner_r;

    // Datapath helpers: current byte address, outgoing store byte, and word with the arriving byte merged in.
    always_comb begin
        cur_addr_s      = addr_r + {29'd0, k_r};
        wr_byte_s       = wdata_r[{k_r[1:0], 3'b000} +: 8];
        cap_idx_s       = k_r[1:0] - 2'd1;
        rdata_cap_s     = rdata_r;
        rdata_cap_s[{cap_idx_s, 3'b000} +: 8] = ram_din_i;
        mem_req_valid_s = (mem_request_i == 2'b01) || (mem_request_i == 2'b10);
        case (mem_width_i)
            2'b00:   len_s = 3'd1;
            2'b01:   len_s = 3'd2;
            default: len_s = 3'd4;
        endcase
    end

    // Next-state and RAM-port control.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        cap_pend_s  = 1'b0;
        gap_s       = 1'b0;
        rdata_s     = rdata_r;
        done_s      = 1'b0;
        rdata_out_s = mem_rdata_r;
        owner_s     = 2'b00;
        lat_s       = 1'b0;
        ram_addr_s  = 32'd0;
        ram_dout_s  = 8'd0;
        ram_wr_s    = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_req_valid_s) begin
                    stall_s = 1'b1;
                    lat_s   = 1'b1;
                    k_s     = 3'd0;
                    rdata_s = 32'd0;
                    state_s = (mem_request_i == 2'b01) ? ST_READ : ST_WRITE;
                end else if (if_request_i) begin
                    ram_addr_s = if_addr_i;
                    owner_s    = 2'b01;
                end else begin
                    ram_addr_s = 32'd0;
                end
            end
            ST_READ: begin
                stall_s = 1'b1;
                // Byte issued last cycle lands now; in IO mode this is the idle gap cycle.
                if (cap_pend_r) begin
                    rdata_s = rdata_cap_s;
                end else begin
                    rdata_s = rdata_r;
                end
                if (!gap_r && (k_r < len_r)) begin
                    ram_addr_s = cur_addr_s;
                    owner_s    = 2'b10;
                    k_s        = k_r + 3'd1;
                    cap_pend_s = 1'b1;
`ifdef MEM_CTRL_IO_WAIT_EN
                    gap_s      = is_io(cur_addr_s);
`else
                    gap_s      = 1'b0;
`endif
                end else if (cap_pend_r && (k_r == len_r)) begin
                    done_s      = 1'b1;
                    rdata_out_s = rdata_cap_s;
                    state_s     = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                stall_s = 1'b1;
                if (gap_r) begin
                    state_s = ST_WRITE;
                end else begin
                    ram_addr_s = cur_addr_s;
                    ram_dout_s = wr_byte_s;
                    ram_wr_s   = 1'b1;
                    if (k_r == (len_r - 3'd1)) begin
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        k_s   = k_r + 3'd1;
`ifdef MEM_CTRL_IO_WAIT_EN
                        gap_s = is_io(cur_addr_s);
`else
                        gap_s = 1'b0;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // RAM port and stall are combinational, so force them quiet while reset is held.
    always_comb begin
        if (rst) begin
            ram_addr_o  = 32'd0;
            ram_dout_o  = 8'd0;
            ram_wr_o    = 1'b0;
            stall_req_o = 1'b0;
        end else begin
            ram_addr_o  = ram_addr_s;
            ram_dout_o  = ram_dout_s;
            ram_wr_o    = ram_wr_s;
            stall_req_o = stall_s;
        end
    end

    // State, transfer context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 32'd0;
            len_r       <= 3'd0;
            wdata_r     <= 32'd0;
            k_r         <= 3'd0;
            rdata_r     <= 32'd0;
            cap_pend_r  <= 1'b0;
            gap_r       <= 1'b0;
            mem_rdata_r <= 32'd0;
            mem_done_r  <= 1'b0;
            owner_r     <= 2'b00;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            rdata_r     <= rdata_s;
            cap_pend_r  <= cap_pend_s;
            gap_r       <= gap_s;
            mem_rdata_r <= rdata_out_s;
            mem_done_r  <= done_s;
            owner_r     <= owner_s;
            if (lat_s) begin
                addr_r  <= mem_addr_i;
                len_r   <= len_s;
                wdata_r <= mem_wdata_i;
            end else begin
                addr_r  <= addr_r;
                len_r   <= len_r;
                wdata_r <= wdata_r;
            end
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller sitting between the IF stage, the MEM stage and the single-port 8-bit RAM. It is the responder for the IF byte-fetch protocol and for MEM load/store requests. It arbitrates the RAM port with MEM having priority, and sequences 1/2/4-byte MEM transfers. While a MEM transfer owns the bus it raises a stall request that ctrl turns into `stall_sign[0]`.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset (`RstEnable`).
- `if_request_i` in 1: IF wants the byte at `if_addr_i` this cycle.
- `if_addr_i` in 32: IF byte address.
- `mem_ctrl_data_o` out 8: returned RAM byte, equal to `ram_din_i`, combinational.
- `if_or_mem_o` out 2: owner of the byte on `mem_ctrl_data_o`. 01 = IF, 10 = MEM, 00 = none.
- `mem_request_i` in 2: 00 none, 01 load, 10 store, 11 treated as none.
- `mem_addr_i` in 32: MEM start byte address.
- `mem_width_i` in 2: 00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- `mem_wdata_i` in 32: store data, little-endian.
- `mem_rdata_o` out 32: load result, zero-extended.
- `mem_done_o` out 1: one-cycle completion pulse.
- `stall_req_o` out 1: MEM owns or is claiming the bus.
- `ram_din_i` in 8: RAM read data, one cycle after the address.
- `ram_dout_o` out 8: RAM write data.
- `ram_addr_o` out 32: RAM byte address.
- `ram_wr_o` out 1: RAM write enable.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If `mem_request_i` is 01 or 10: latch address, width (N = 1/2/4) and wdata, clear byte counter `k`, and go to READ or WRITE.
  - Otherwise the IF path is transparent: `ram_addr_o = if_addr_i`, `ram_wr_o = 0`.
  - `ram_addr_o` is 0 when `if_request_i` is 0.
- READ:
  - Drive `ram_addr_o = addr + k`, `ram_wr_o = 0`.
  - Byte k is captured into `rdata[8k+7:8k]` on the edge one cycle after its address is issued.
  - After the last capture: `mem_rdata_o` <= assembled word with unused upper bytes 0, `mem_done_o` <= 1, go to DONE.
- WRITE:
  - Drive `ram_addr_o = addr + k`, `ram_dout_o = wdata[8k+7:8k]`, `ram_wr_o = 1`.
  - After byte N-1: `mem_done_o` <= 1, go to DONE.
- DONE: RAM idle (`ram_wr_o = 0`), request ignored, go to IDLE unconditionally.
- `stall_req_o`: combinational. It is 1 when in IDLE with `mem_request_i` ∈ {01, 10}, or when in READ/WRITE. It is 0 in DONE.
- `if_or_mem_o`: registered owner of the address driven in the previous cycle. 01 = IF read, 10 = MEM read, 00 = write or idle.
- IF bytes in flight when MEM seizes the bus are dropped; IF refetches.
- Address arithmetic wraps modulo 2^32.
- `mem_rdata_o` holds its value until the next load completes.
- Reset, including mid-transfer: state IDLE, counters 0, all outputs 0 except `mem_ctrl_data_o` (follows `ram_din_i`). The partial transfer is abandoned.

## Timing
- Cycle 0 is the cycle the MEM request is first seen in IDLE.
- Load, N bytes: byte k address in cycle k+1, data in cycle k+2. `mem_done_o` high in cycle N+2. `stall_req_o` high cycles 0..N+1.
- Store, N bytes: byte k written in cycle k+1. `mem_done_o` high in cycle N+1.
- The MEM stage must hold its request stable until it sees `mem_done_o`. It drops the request at the following edge; DONE absorbs that cycle.
- IF path: address to RAM combinationally in the same cycle. The byte is valid on `mem_ctrl_data_o` one cycle later, with `if_or_mem_o = 01`.

## Configuration
- `MEM_CTRL_IO_WAIT_EN` defined:
  - Every MEM byte access whose address has bits [17:16] == 2'b11 (IO space) is followed by one idle cycle before the next byte (`ram_wr_o = 0`, `ram_addr_o = 0`).
  - IO load: byte k address in cycle 2k+1, `mem_done_o` in cycle 2N+1.
  - IO store: byte k written in cycle 2k+1, `mem_done_o` in cycle 2N.
- Undefined: IO space is handled identically to RAM, with no gaps.

## Test plan
- IF only, `if_request_i = 1`, addr 0x10 then 0x11, RAM holds 0x93, 0x00: `ram_addr_o` follows same cycle; next cycles `mem_ctrl_data_o` = 0x93 then 0x00 with `if_or_mem_o = 01`; `stall_req_o = 0` throughout.
- Word load at 0x100, RAM bytes 0x78, 0x56, 0x34, 0x12: addresses 0x100..0x103 in cycles 1..4; `mem_done_o` in cycle 6 with `mem_rdata_o` = 0x12345678; `stall_req_o` high cycles 0..5.
- Half store 0xBEEF at 0x201: cycle 1 writes 0xEF at 0x201, cycle 2 writes 0xBE at 0x202; `mem_done_o` in cycle 3; a later 1-byte load at 0x202 returns 0x000000BE.
- MEM load issued while IF is mid-fetch with `if_request_i` high: IF address is replaced the same cycle; `if_or_mem_o` = 10 for MEM bytes; after DONE the IF address reaches the RAM again.
- `rst` asserted in cycle 2 of a word store: only byte 0 written, then all outputs 0 and state IDLE; no `mem_done_o`.
- With `MEM_CTRL_IO_WAIT_EN`, 2-byte store at 0x30000: writes in cycles 1 and 3, idle in cycle 2, `mem_done_o` in cycle 4; without the macro, `mem_done_o` in cycle 3.
